// File: rtl/seg_scan_ctrl_if.sv
// Load handshake for seg_scan_ctrl.
//   load_valid  master->slave  new display word offered
//   load_data   master->slave  four hex digits, digit i = [4i+3:4i]
//   load_dp     master->slave  decimal point per digit, 1 = lit
//   load_ready  slave->master  pending buffer is free
interface seg_scan_ctrl_if;
  logic        load_valid;
  logic [15:0] load_data;
  logic [3:0]  load_dp;
  logic        load_ready;

  modport master (output load_valid, load_data, load_dp, input load_ready);
  modport slave  (input load_valid, load_data, load_dp, output load_ready);
endinterface

// File: rtl/seg_scan_ctrl.sv
// 4-digit multiplexed 7-segment scan controller.
// Each digit owns a slot of SLOT_CYCLES clocks; the first BLANK_CYCLES of a
// slot are dark to avoid ghosting. New words land in a one-entry pending
// buffer and are committed only at the frame boundary so a frame never tears.
// Ports:
//   clk         board clock
//   btnC        asynchronous active-high reset
//   ld          load handshake (slave side)
//   digit_en    per-digit enable, 0 = dark in its slot
//   blank_all   force all digits dark, scan keeps running
//   seg/dp/an   active-low segment {g..a}, decimal point, anodes (registered)
//   frame_done  one-cycle pulse after the last cycle of a 4-digit frame
module seg_scan_ctrl #(
  parameter int SLOT_CYCLES  = 3052,
  parameter int BLANK_CYCLES = 64
) (
  input  logic           clk,
  input  logic           btnC,
  seg_scan_ctrl_if.slave ld,
  input  logic [3:0]     digit_en,
  input  logic           blank_all,
  output logic [6:0]     seg,
  output logic           dp,
  output logic [3:0]     an,
  output logic           frame_done
);
  localparam int CW = $clog2(SLOT_CYCLES);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  logic [CW-1:0]   cnt;
  logic [1:0]      idx;
  logic [3:0][3:0] disp_data, pend_data;
  logic [3:0]      disp_dp, pend_dp;
  logic            pend_valid;

  logic            slot_end, frame_end, load_fire, lit;
  logic [0:0]      state;
  logic [3:0]      an_nxt;
  logic [6:0]      seg_nxt;
  logic            dp_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  assign slot_end      = (cnt == CW'(SLOT_CYCLES - 1));
  assign frame_end     = slot_end & (idx == 2'd3);
  assign state         = (cnt < CW'(BLANK_CYCLES)) ? ST_BLANK : ST_SHOW;
  assign ld.load_ready = ~pend_valid;
  assign load_fire     = ld.load_valid & ~pend_valid;

  always_comb begin
    lit     = (state == ST_SHOW) & digit_en[idx] & ~blank_all;
    an_nxt  = 4'hF;
    seg_nxt = 7'h7F;
    dp_nxt  = 1'b1;
    if (lit) begin
      an_nxt  = ~(4'b0001 << idx);
      seg_nxt = hex7(disp_data[idx]);
      dp_nxt  = ~disp_dp[idx];
    end
  end

  // scan timing
  always_ff @(posedge clk or posedge btnC) begin
    if (btnC) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // pending buffer and frame-aligned commit; a word accepted on the boundary
  // cycle sees pend_valid=0 there, so it naturally waits a full frame
  always_ff @(posedge clk or posedge btnC) begin
    if (btnC) begin
      pend_valid <= 1'b0;
      pend_data  <= '0;
      pend_dp    <= '0;
      disp_data  <= '0;
      disp_dp    <= '0;
    end else begin
      if (load_fire) begin
        pend_valid <= 1'b1;
        pend_data  <= ld.load_data;
        pend_dp    <= ld.load_dp;
      end
      if (frame_end && pend_valid) begin
        disp_data  <= pend_data;
        disp_dp    <= pend_dp;
        pend_valid <= 1'b0;
      end
    end
  end

  // registered display outputs, one cycle behind cnt/idx
  always_ff @(posedge clk or posedge btnC) begin
    if (btnC) begin
      an         <= 4'hF;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an         <= an_nxt;
      seg        <= seg_nxt;
      dp         <= dp_nxt;
      frame_done <= frame_end;
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;
  logic       clk, btnC;
  logic [3:0] digit_en;
  logic       blank_all;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frame_done;
  int         k, pass_cnt, total;

  seg_scan_ctrl_if ifc ();

  seg_scan_ctrl #(.SLOT_CYCLES(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .btnC(btnC), .ld(ifc.slave), .digit_en(digit_en),
    .blank_all(blank_all), .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s k=%0d obs=%h exp=%h", tag, k, obs, exp);
  endtask

  // k counts posedges since reset release; outputs at k reflect state k-1
  task automatic step();
    @(negedge clk);
    k++;
  endtask

  task automatic goto(input int t);
    while (k < t) step();
  endtask

  task automatic show_chk(input string tag, input int t, input logic [3:0] ea,
                          input logic [6:0] es, input logic ed);
    goto(t);
    chk({tag, "_an"}, an, ea);
    chk({tag, "_seg"}, seg, es);
    chk({tag, "_dp"}, dp, ed);
  endtask

  function automatic logic [3:0] exp_an(input int kk, input logic [3:0] en, input logic blk);
    int c, i;
    c = (kk - 1) % 8;
    i = ((kk - 1) / 8) % 4;
    if (c < 2 || !en[i] || blk) return 4'hF;
    return ~(4'b0001 << i);
  endfunction

  function automatic void load(input logic [15:0] d, input logic [3:0] p);
    ifc.load_valid = 1'b1;
    ifc.load_data  = d;
    ifc.load_dp    = p;
  endfunction

  initial begin
    logic [3:0] ea;
    logic [6:0] es;
    k = 0; pass_cnt = 0; total = 0;
    btnC = 1'b1; digit_en = 4'hF; blank_all = 1'b0;
    ifc.load_valid = 1'b0; ifc.load_data = '0; ifc.load_dp = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_fd", frame_done, 1'b0);
    chk("rst_rdy", ifc.load_ready, 1'b1);
    btnC = 1'b0;
    k = 0;

    // plain scan of zeros, two frames
    for (int t = 1; t <= 64; t++) begin
      step();
      ea = exp_an(k, 4'hF, 1'b0);
      chk("scan_an", an, ea);
      chk("scan_seg", seg, (ea == 4'hF) ? 7'h7F : 7'h40);
      chk("scan_dp", dp, 1'b1);
      chk("scan_fd", frame_done, (k % 32 == 0));
    end

    // mid-frame load, committed at the boundary
    goto(70);
    chk("ld1_rdy0", ifc.load_ready, 1'b1);
    load(16'h8F10, 4'b0001);
    step();
    ifc.load_valid = 1'b0;
    chk("ld1_busy", ifc.load_ready, 1'b0);
    show_chk("ld1_old", 91, 4'h7, 7'h40, 1'b1);
    goto(95);
    chk("ld1_busy95", ifc.load_ready, 1'b0);
    step();
    chk("ld1_free", ifc.load_ready, 1'b1);
    show_chk("ld1_d0", 99, 4'hE, 7'h40, 1'b0);
    show_chk("ld1_d1", 107, 4'hD, 7'h79, 1'b1);
    show_chk("ld1_d2", 115, 4'hB, 7'h0E, 1'b1);
    show_chk("ld1_d3", 123, 4'h7, 7'h00, 1'b1);

    // second word while busy is dropped
    goto(130);
    load(16'h1234, 4'b0000);
    step();
    ifc.load_valid = 1'b0;
    goto(135);
    chk("ldB_busy", ifc.load_ready, 1'b0);
    load(16'h5678, 4'b1111);
    step();
    ifc.load_valid = 1'b0;
    goto(160);
    chk("ldA_free", ifc.load_ready, 1'b1);
    show_chk("ldA_d0", 163, 4'hE, 7'h19, 1'b1);
    goto(165);
    load(16'h5678, 4'b1111);
    step();
    ifc.load_valid = 1'b0;
    show_chk("ldA_d3", 187, 4'h7, 7'h79, 1'b1);
    show_chk("ldB_d0", 195, 4'hE, 7'h00, 1'b0);
    show_chk("ldB_d2", 211, 4'hB, 7'h02, 1'b0);

    // word accepted on the boundary cycle waits one full frame
    goto(223);
    chk("bnd_rdy", ifc.load_ready, 1'b1);
    load(16'hABCD, 4'b0000);
    step();
    ifc.load_valid = 1'b0;
    chk("bnd_busy", ifc.load_ready, 1'b0);
    show_chk("bnd_keep", 227, 4'hE, 7'h00, 1'b0);
    show_chk("bnd_new0", 259, 4'hE, 7'h21, 1'b1);
    show_chk("bnd_new3", 283, 4'h7, 7'h08, 1'b1);

    // digit_en=0101 and a 3-cycle blank_all pulse inside digit-0 show
    goto(286);
    digit_en = 4'b0101;
    for (int t = 287; t <= 320; t++) begin
      step();
      ea = exp_an(k, 4'b0101, (k >= 292 && k <= 294));
      es = (ea == 4'hE) ? 7'h21 : (ea == 4'hB) ? 7'h03 : 7'h7F;
      chk("en_an", an, ea);
      chk("en_seg", seg, es);
      chk("en_fd", frame_done, (k % 32 == 0));
      if (k == 291) blank_all = 1'b1;
      if (k == 294) blank_all = 1'b0;
    end

    // reset mid-slot with a word pending
    digit_en = 4'hF;
    goto(330);
    load(16'hFFFF, 4'hF);
    step();
    ifc.load_valid = 1'b0;
    chk("rs_busy", ifc.load_ready, 1'b0);
    goto(341);
    chk("rs_lit", an, 4'hB);
    #1 btnC = 1'b1;
    #1;
    chk("rs_an", an, 4'hF);
    chk("rs_seg", seg, 7'h7F);
    chk("rs_dp", dp, 1'b1);
    chk("rs_rdy", ifc.load_ready, 1'b1);
    @(negedge clk); @(negedge clk);
    btnC = 1'b0;
    k = 0;
    show_chk("rs_zero", 3, 4'hE, 7'h40, 1'b1);
    show_chk("rs_zero3", 27, 4'h7, 7'h40, 1'b1);
    goto(31);
    chk("rs_fd31", frame_done, 1'b0);
    step();
    chk("rs_fd32", frame_done, 1'b1);
    chk("rs_rdy2", ifc.load_ready, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter SLOT_CYCLES, default 3052: clk cycles per digit slot; legal range 4..4095.
REQ-002 Parameter BLANK_CYCLES, default 64: blanking cycles at the start of each slot; legal range 1..SLOT_CYCLES-2.
REQ-003 clk  in  1  board clock; the only clock.
REQ-004 btnC  in  1  reset; asynchronous, active-high.
REQ-005 load_valid  in  1  new display word offered.
REQ-006 load_data  in  16  four hex digits; digit i = load_data[4i+3:4i].
REQ-007 load_dp  in  4  decimal point per digit; 1 = lit.
REQ-008 load_ready  out  1  block can accept a word.
REQ-009 digit_en  in  4  per-digit enable; 0 = digit kept dark in its slot.
REQ-010 blank_all  in  1  forces all digits dark; scan timing continues.
REQ-011 seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-012 dp  out  1  decimal point, active-low.
REQ-013 an  out  4  digit anodes, active-low, one-hot-low or all-high.
REQ-014 frame_done  out  1  one-cycle pulse at end of each 4-digit frame.

Function
REQ-015 The block SHALL keep a slot counter cnt (0..SLOT_CYCLES-1) and a digit index idx (0..3); cnt increments every cycle and wraps to 0 after SLOT_CYCLES-1.
REQ-016 On each cnt wrap, idx SHALL increment; idx wraps from 3 to 0.
REQ-017 State is BLANK when cnt < BLANK_CYCLES, else SHOW.
REQ-018 In BLANK, an=4'b1111, seg=7'h7F, dp=1.
REQ-019 In SHOW, if digit_en[idx]=1 and blank_all=0: an[idx]=0, others 1; seg = hex decode of display digit idx; dp = ~disp_dp[idx]. Otherwise as BLANK.
REQ-020 Hex decode SHALL use standard patterns; for example 0 -> 7'h40, 1 -> 7'h79, 8 -> 7'h00, F -> 7'h0E (active-low, {g..a}).
REQ-021 seg, dp, an and frame_done SHALL be registered, one cycle behind the (idx, cnt, inputs) that produce them.
REQ-022 frame_done SHALL be 1 for exactly one cycle following the cycle where idx=3 and cnt=SLOT_CYCLES-1.
REQ-023 The load path SHALL hold a single pending buffer (pend_data, pend_dp, pend_valid); load_ready = ~pend_valid, combinational from the register.
REQ-024 load_valid & load_ready at a clock edge SHALL capture load_data/load_dp into pend and set pend_valid.
REQ-025 At the frame boundary cycle (idx=3, cnt=SLOT_CYCLES-1), if pend_valid=1 the display registers SHALL take pend and pend_valid SHALL clear, so new content starts at digit 0 with no tearing.
REQ-026 A word accepted in the frame boundary cycle itself SHALL go to pend and be committed at the next boundary; there is no bypass.
REQ-027 load_valid while load_ready=0 SHALL be ignored; the offered word is not captured.
REQ-028 digit_en and blank_all changes SHALL take effect on the next cycle, mid-slot included, without disturbing cnt or idx.

Reset
REQ-029 While btnC=1: cnt=0, idx=0, display data=0, disp_dp=0, pend_valid=0, an=4'b1111, seg=7'h7F, dp=1, frame_done=0, load_ready=1.
REQ-030 Reset asserted mid-slot or mid-load SHALL discard pending and displayed data immediately (asynchronous). After release, scanning restarts at idx=0, cnt=0.

Verification
(All scenarios use SLOT_CYCLES=8 and BLANK_CYCLES=2.)
REQ-031 Reset, then digit_en=4'hF with no load -> each 8-cycle slot shows 2 cycles an=4'hF, then 6 cycles an=~(1<<idx) with seg=7'h40; frame_done pulses every 32 cycles.
REQ-032 Load 16'h8F10 with load_dp=4'b0001 mid-frame -> load_ready=0 until the boundary; the next frame shows digit0=7'h40 with dp=0, digit1=7'h79, digit2=7'h0E, digit3=7'h00.
REQ-033 Load word A, then word B while load_ready=0 -> B is ignored; after the boundary load_ready=1, and B reloaded is displayed one frame later.
REQ-034 Word accepted exactly in the boundary cycle -> the current frame keeps old data; the word appears in the following frame.
REQ-035 digit_en=4'b0101, then blank_all pulsed for 3 cycles inside a digit-0 SHOW -> digits 1 and 3 are never driven; digit 0 goes dark for exactly 3 cycles; frame_done period is unchanged.
REQ-036 btnC asserted with pend_valid=1 at idx=2 -> outputs go dark in the same cycle; after release load_ready=1, the display shows 0s, and the first frame_done comes 32 cycles later.
